// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, parity and word-length codes,
// and the word-length / parity helpers used by both the transmitter and receiver.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam logic [3:0] WL5 = 4'b0101;
  localparam logic [3:0] WL6 = 4'b0110;
  localparam logic [3:0] WL7 = 4'b0111;
  localparam logic [3:0] WL8 = 4'b1000;

  // Unrecognised word-length codes fall back to 8 bits.
  function automatic logic [3:0] word_bits(input logic [3:0] code);
    case (code)
      WL5:     word_bits = 4'd5;
      WL6:     word_bits = 4'd6;
      WL7:     word_bits = 4'd7;
      WL8:     word_bits = 4'd8;
      default: word_bits = 4'd8;
    endcase
  endfunction

  function automatic logic [7:0] word_mask(input logic [3:0] code);
    case (code)
      WL5:     word_mask = 8'h1F;
      WL6:     word_mask = 8'h3F;
      WL7:     word_mask = 8'h7F;
      WL8:     word_mask = 8'hFF;
      default: word_mask = 8'hFF;
    endcase
  endfunction

  // Data must already be masked so unused bits count as zero.
  function automatic logic parity_bit(input logic [1:0] ptype, input logic [7:0] data);
    case (ptype)
      PAR_ODD:  parity_bit = ~^data;
      PAR_EVEN: parity_bit = ^data;
      default:  parity_bit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/tx_controller.sv
// UART transmitter: start bit, 5..8 data bits LSB first, optional parity, one stop bit;
// each bit held for BIT_CYCLES bclk cycles. Outputs are registered from the current state.
module tx_controller
  import uart_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 16
) (
  input  logic       bclk,
  input  logic       rstn,
  input  logic       tx_start,
  input  logic [7:0] din,
  input  logic [3:0] frame_size,
  input  logic [1:0] parity_type,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(BIT_CYCLES - 1);

  logic [2:0]    state_r;
  logic [2:0]    state_nxt_s;
  logic [CW-1:0] clk_cnt_r;
  logic [2:0]    bit_cnt_r;
  logic [3:0]    nbits_r;
  logic [1:0]    par_r;
  logic [7:0]    data_r;
  logic [7:0]    shift_r;
  logic          tx_r;
  logic          tx_busy_r;
  logic          tx_done_r;
  logic          tx_nxt_s;
  logic          bit_end_s;
  logic          last_bit_s;
  logic          par_en_s;
  logic          accept_s;

  assign bit_end_s  = (clk_cnt_r == CLK_LAST);
  assign last_bit_s = ({1'b0, bit_cnt_r} == (nbits_r - 4'd1));
  assign par_en_s   = (par_r == PAR_ODD) || (par_r == PAR_EVEN);
  assign accept_s   = (state_r == ST_IDLE) && tx_start;

  // Next-state decode for the frame sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (tx_start) state_nxt_s = ST_START;
        else          state_nxt_s = ST_IDLE;
      end
      ST_START: begin
        if (bit_end_s) state_nxt_s = ST_DATA;
        else           state_nxt_s = ST_START;
      end
      ST_DATA: begin
        if (bit_end_s && last_bit_s) state_nxt_s = par_en_s ? ST_PARITY : ST_STOP;
        else                         state_nxt_s = ST_DATA;
      end
      ST_PARITY: begin
        if (bit_end_s) state_nxt_s = ST_STOP;
        else           state_nxt_s = ST_PARITY;
      end
      ST_STOP: begin
        if (bit_end_s) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_STOP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge bclk or negedge rstn) begin
    if (!rstn) state_r <= ST_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Cycle-within-bit counter; every state change lands on a bit boundary, so it restarts there.
  always_ff @(posedge bclk or negedge rstn) begin
    if (!rstn)                              clk_cnt_r <= '0;
    else if (state_r == ST_IDLE || bit_end_s) clk_cnt_r <= '0;
    else                                    clk_cnt_r <= clk_cnt_r + 1'b1;
  end

  // Data bit index, only advances inside DATA.
  always_ff @(posedge bclk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt_r <= 3'd0;
    end else if (state_r != ST_DATA) begin
      bit_cnt_r <= 3'd0;
    end else if (bit_end_s) begin
      bit_cnt_r <= last_bit_s ? 3'd0 : bit_cnt_r + 3'd1;
    end else begin
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // Shadow registers captured on acceptance; the shift copy drains LSB first.
  always_ff @(posedge bclk or negedge rstn) begin
    if (!rstn) begin
      data_r  <= 8'h00;
      shift_r <= 8'h00;
      nbits_r <= 4'd0;
      par_r   <= PAR_NONE;
    end else if (accept_s) begin
      data_r  <= din & word_mask(frame_size);
      shift_r <= din & word_mask(frame_size);
      nbits_r <= word_bits(frame_size);
      par_r   <= ((parity_type == PAR_ODD) || (parity_type == PAR_EVEN)) ? parity_type : PAR_NONE;
    end else if (state_r == ST_DATA && bit_end_s) begin
      shift_r <= {1'b0, shift_r[7:1]};
    end else begin
      shift_r <= shift_r;
    end
  end

  // Line level for the current state, registered below.
  always_comb begin
    tx_nxt_s = 1'b1;
    case (state_r)
      ST_IDLE:   tx_nxt_s = 1'b1;
      ST_START:  tx_nxt_s = 1'b0;
      ST_DATA:   tx_nxt_s = shift_r[0];
      ST_PARITY: tx_nxt_s = parity_bit(par_r, data_r);
      ST_STOP:   tx_nxt_s = 1'b1;
      default:   tx_nxt_s = 1'b1;
    endcase
  end

  // tx/busy lag the state by one cycle; done fires on the first cycle busy drops.
  always_ff @(posedge bclk or negedge rstn) begin
    if (!rstn) begin
      tx_r      <= 1'b1;
      tx_busy_r <= 1'b0;
      tx_done_r <= 1'b0;
    end else begin
      tx_r      <= tx_nxt_s;
      tx_busy_r <= (state_r != ST_IDLE);
      tx_done_r <= (state_r == ST_IDLE) && tx_busy_r;
    end
  end

  assign tx      = tx_r;
  assign tx_busy = tx_busy_r;
  assign tx_done = tx_done_r;

endmodule

// File: tb/tb_tx_controller.sv
// Self-checking bench for tx_controller: per-cycle {tx,tx_busy,tx_done} against a
// bit-list frame model built from the word length, parity and data.
module tb_tx_controller;

  logic       bclk = 1'b0;
  logic       rstn;
  logic       tx_start;
  logic [7:0] din;
  logic [3:0] frame_size;
  logic [1:0] parity_type;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  logic [2:0] exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  always #5 bclk = ~bclk;

  tx_controller #(.BIT_CYCLES(16)) dut (
    .bclk        (bclk),
    .rstn        (rstn),
    .tx_start    (tx_start),
    .din         (din),
    .frame_size  (frame_size),
    .parity_type (parity_type),
    .tx          (tx),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done)
  );

  // Appends one frame (16 cycles per bit) plus the done cycle to exp_q as {tx,busy,done}.
  task automatic model_frame(input logic [7:0] d, input logic [3:0] fs, input logic [1:0] pt);
    int n;
    int ones;
    bit b[$];
    n = (fs >= 4'd5 && fs <= 4'd8) ? int'(fs) : 8;
    ones = 0;
    b.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      b.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pt == 2'b01)      b.push_back((ones % 2) == 0);
    else if (pt == 2'b10) b.push_back((ones % 2) == 1);
    b.push_back(1'b1);
    foreach (b[k]) repeat (16) exp_q.push_back({b[k], 1'b1, 1'b0});
    exp_q.push_back(3'b101);
  endtask

  task automatic push_idle(input int n);
    repeat (n) exp_q.push_back(3'b100);
  endtask

  // Presents a request at a falling edge; returns at the falling edge after the sampling edge.
  task automatic kick(input logic [7:0] d, input logic [3:0] fs, input logic [1:0] pt);
    @(negedge bclk);
    din = d; frame_size = fs; parity_type = pt; tx_start = 1'b1;
    @(negedge bclk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; tx_start = 1'b0; din = 8'h00; frame_size = 4'd8; parity_type = 2'b00;
    repeat (3) @(negedge bclk);
    n_checks++;
    if ({tx, tx_busy, tx_done} !== 3'b100)
      $display("FAIL reset_state: got %b expected %b", {tx, tx_busy, tx_done}, 3'b100);
    else n_pass++;
    rstn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge bclk);
      n_checks++;
      if ({tx, tx_busy, tx_done} !== 3'b100)
        $display("FAIL idle cycle %0d: got %b expected %b", i, {tx, tx_busy, tx_done}, 3'b100);
      else n_pass++;
    end
  endtask

  task automatic test_frame(input string name, input logic [7:0] d, input logic [3:0] fs,
                            input logic [1:0] pt);
    exp_q.delete();
    model_frame(d, fs, pt);
    push_idle(4);
    kick(d, fs, pt);
    tx_start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge bclk);
      n_checks++;
      if ({tx, tx_busy, tx_done} !== exp_q[i])
        $display("FAIL %s cycle %0d: got %b expected %b", name, i + 1, {tx, tx_busy, tx_done}, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      test_frame("random", 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_midframe_changes();
    logic [7:0] d;
    d = 8'($urandom_range(0, 255));
    exp_q.delete();
    model_frame(d, 4'd8, 2'b10);
    push_idle(20);
    kick(d, 4'd8, 2'b10);
    tx_start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge bclk);
      n_checks++;
      if ({tx, tx_busy, tx_done} !== exp_q[i])
        $display("FAIL midframe cycle %0d: got %b expected %b", i + 1, {tx, tx_busy, tx_done}, exp_q[i]);
      else n_pass++;
      if (i == 40) begin
        tx_start = 1'b1; din = ~d; frame_size = 4'd5; parity_type = 2'b01;
      end else if (i == 41) begin
        tx_start = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d1;
    logic [7:0] d2;
    int len1;
    d1 = 8'($urandom_range(0, 255));
    d2 = 8'($urandom_range(0, 255));
    exp_q.delete();
    model_frame(d1, 4'd7, 2'b00);
    len1 = exp_q.size();
    model_frame(d2, 4'd7, 2'b01);
    push_idle(10);
    kick(d1, 4'd7, 2'b00);
    din = d2; parity_type = 2'b01;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge bclk);
      n_checks++;
      if ({tx, tx_busy, tx_done} !== exp_q[i])
        $display("FAIL back_to_back cycle %0d: got %b expected %b", i + 1, {tx, tx_busy, tx_done}, exp_q[i]);
      else n_pass++;
      if (i == len1 + 10) tx_start = 1'b0;
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    d = 8'($urandom_range(0, 255)) & 8'hF7;
    exp_q.delete();
    model_frame(d, 4'd8, 2'b00);
    kick(d, 4'd8, 2'b00);
    tx_start = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge bclk);
      n_checks++;
      if ({tx, tx_busy, tx_done} !== exp_q[i])
        $display("FAIL pre_reset cycle %0d: got %b expected %b", i + 1, {tx, tx_busy, tx_done}, exp_q[i]);
      else n_pass++;
    end
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if ({tx, tx_busy, tx_done} !== 3'b100)
      $display("FAIL async_reset: got %b expected %b", {tx, tx_busy, tx_done}, 3'b100);
    else n_pass++;
    @(negedge bclk);
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge bclk);
      n_checks++;
      if ({tx, tx_busy, tx_done} !== 3'b100)
        $display("FAIL post_reset cycle %0d: got %b expected %b", i, {tx, tx_busy, tx_done}, 3'b100);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_frame("8n1_a5", 8'hA5, 4'b1000, 2'b00);
    test_frame("7o1_ff", 8'hFF, 4'b0111, 2'b01);
    test_frame("7e1_ff", 8'hFF, 4'b0111, 2'b10);
    test_frame("5e1_e3", 8'hE3, 4'b0101, 2'b10);
    test_frame("6p11_3c", 8'h3C, 4'b0110, 2'b11);
    test_frame("illegal_fs", 8'h81, 4'b1111, 2'b01);
    test_random();
    test_midframe_changes();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
